// File: rtl/serial_port_demux_tx.sv
// rtl/serial_port_demux_tx.sv - serial frame demultiplexer onto per-port data lines
//
// Purpose:
//   Watches a gated serial bit stream for a start pattern. A frame follows:
//     start pattern (START_LEN bits, MSB first), port (PORT_W bits, MSB first),
//     count (CNT_W bits, MSB first), then `count` payload bits.
//   Each payload bit is registered onto sd[port] with a matching one-hot pulse
//   on sd_valid in the following cycle. A one-cycle done pulse ends every frame.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-low reset
//   en        in   bit enable; serIn is consumed only on edges with en=1
//   serIn     in   serial data stream
//   sd        out  [NUM_PORTS] registered per-port data
//   sd_valid  out  [NUM_PORTS] one-hot valid, one cycle after each payload bit
//   busy      out  high whenever a frame is in progress (state != IDLE)
//   done      out  one-cycle end-of-frame pulse

module serial_port_demux_tx #(
  parameter int                   START_LEN = 4,
  parameter logic [START_LEN-1:0] START_SEQ = 4'b1101,
  parameter int                   PORT_W    = 2,
  parameter int                   CNT_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   serIn,
  output logic [2**PORT_W-1:0]   sd,
  output logic [2**PORT_W-1:0]   sd_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int NUM_PORTS = 2**PORT_W;
  localparam int MAX_DATA  = 2**CNT_W - 1;

  // One counter serves every phase, so it must hold the largest field length
  // or payload size without wrapping.
  localparam int MAX_A = (START_LEN > PORT_W) ? START_LEN : PORT_W;
  localparam int MAX_B = (MAX_A > CNT_W) ? MAX_A : CNT_W;
  localparam int MAX_V = (MAX_B > MAX_DATA) ? MAX_B : MAX_DATA;
  localparam int BIT_W = $clog2(MAX_V + 1);

  // Lengths in the width of the incremented counter (one extra bit).
  localparam logic [BIT_W:0] LEN_START = (BIT_W+1)'(START_LEN);
  localparam logic [BIT_W:0] LEN_PORT  = (BIT_W+1)'(PORT_W);
  localparam logic [BIT_W:0] LEN_CNT   = (BIT_W+1)'(CNT_W);
  localparam logic [BIT_W:0] ONE_INC   = (BIT_W+1)'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PORT  = 3'd1,
    COUNT = 3'd2,
    DATA  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_n;
  logic [START_LEN-1:0]   shift_q, shift_n;
  logic [BIT_W-1:0]       bits_q, bits_n;
  logic [PORT_W-1:0]      port_q, port_n;
  logic [CNT_W-1:0]       count_q, count_n;
  logic [NUM_PORTS-1:0]   sd_q, sd_n;
  logic [NUM_PORTS-1:0]   sd_valid_q, sd_valid_n;

  // Shift candidates: each field shifts in MSB first, so the new bit enters
  // at the LSB and the oldest bit falls off the top.
  logic [START_LEN-1:0]   shift_in;
  logic [PORT_W-1:0]      port_in;
  logic [CNT_W-1:0]       count_in;
  logic [BIT_W:0]         bits_inc;
  logic [BIT_W:0]         count_ext;
  logic [NUM_PORTS-1:0]   port_onehot;

  assign shift_in    = START_LEN'({shift_q, serIn});
  assign port_in     = PORT_W'({port_q, serIn});
  assign count_in    = CNT_W'({count_q, serIn});
  assign bits_inc    = {1'b0, bits_q} + ONE_INC;
  assign count_ext   = (BIT_W+1)'(count_q);
  assign port_onehot = NUM_PORTS'(1) << port_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bits_q     <= '0;
      port_q     <= '0;
      count_q    <= '0;
      sd_q       <= '0;
      sd_valid_q <= '0;
    end else begin
      state_q    <= state_n;
      shift_q    <= shift_n;
      bits_q     <= bits_n;
      port_q     <= port_n;
      count_q    <= count_n;
      sd_q       <= sd_n;
      sd_valid_q <= sd_valid_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    shift_n    = shift_q;
    bits_n     = bits_q;
    port_n     = port_q;
    count_n    = count_q;
    sd_n       = sd_q;
    sd_valid_n = '0;

    case (state_q)
      IDLE: begin
        if (en) begin
          shift_n = shift_in;
          // Saturate: once a full pattern's worth of bits has arrived, every
          // further bit can complete an (overlapping) match.
          if (bits_inc <= LEN_START) begin
            bits_n = bits_inc[BIT_W-1:0];
          end
          if (shift_in == START_SEQ && bits_inc >= LEN_START) begin
            state_n = PORT;
            bits_n  = '0;
          end
        end
      end

      PORT: begin
        if (en) begin
          port_n = port_in;
          if (bits_inc == LEN_PORT) begin
            state_n = COUNT;
            bits_n  = '0;
          end else begin
            bits_n = bits_inc[BIT_W-1:0];
          end
        end
      end

      COUNT: begin
        if (en) begin
          count_n = count_in;
          if (bits_inc == LEN_CNT) begin
            bits_n  = '0;
            // An empty frame skips the payload phase entirely.
            state_n = (count_in != '0) ? DATA : DONE;
          end else begin
            bits_n = bits_inc[BIT_W-1:0];
          end
        end
      end

      DATA: begin
        if (en) begin
          sd_n[port_q] = serIn;
          sd_valid_n   = port_onehot;
          if (bits_inc == count_ext) begin
            state_n = DONE;
            bits_n  = '0;
          end else begin
            bits_n = bits_inc[BIT_W-1:0];
          end
        end
      end

      DONE: begin
        // Leaves unconditionally so the done pulse is always one cycle; the
        // search restarts from scratch so frame bits never seed a match.
        state_n = IDLE;
        shift_n = '0;
        bits_n  = '0;
      end

      default: begin
        state_n = IDLE;
        shift_n = '0;
        bits_n  = '0;
      end
    endcase
  end

  assign sd       = sd_q;
  assign sd_valid = sd_valid_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: doc/serial_port_demux_tx.md
SERIAL_PORT_DEMUX_TX -- requirements
Module: serial_port_demux_tx

Interface
REQ-001 SHALL have parameter START_LEN, default 4, start-pattern length in bits (>=2).
REQ-002 SHALL have parameter START_SEQ, default 4'b1101, start pattern; MSB is the first bit received.
REQ-003 SHALL have parameter PORT_W, default 2, port-field width; NUM_PORTS = 2**PORT_W.
REQ-004 SHALL have parameter CNT_W, default 4, count-field width.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-007 SHALL have port en, input, 1, bit-enable; serIn sampled only when en=1.
REQ-008 SHALL have port serIn, input, 1, serial data stream.
REQ-009 SHALL have port sd, output, NUM_PORTS, per-port registered data out.
REQ-010 SHALL have port sd_valid, output, NUM_PORTS, per-port one-hot valid.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-013 SHALL implement FSM states IDLE, PORT, COUNT, DATA, DONE.
REQ-014 An enabled cycle SHALL be a rising edge with en=1; with en=0 all state, counters, shift register and sd SHALL hold and sd_valid SHALL be 0.
REQ-015 IDLE: shift serIn into a START_LEN-bit register each enabled cycle; track bits received since entering IDLE (saturating at START_LEN).
REQ-016 IDLE->PORT SHALL occur on the enabled edge where the register (including the bit just sampled) equals START_SEQ and at least START_LEN bits have been received since entering IDLE (overlapping detection).
REQ-017 PORT: receive PORT_W bits, MSB first, into port register; after the last bit go to COUNT.
REQ-018 COUNT: receive CNT_W bits, MSB first, into count register; after the last bit go to DATA if count != 0, else directly to DONE.
REQ-019 DATA: each enabled cycle, sd[port] <= serIn, sd_valid SHALL equal one-hot(port) in the following cycle (1-cycle latency); other sd bits hold.
REQ-020 DATA SHALL forward exactly count bits (1..2**CNT_W-1), then go to DONE.
REQ-021 sd_valid SHALL be 0 in every cycle not immediately following an enabled DATA edge.
REQ-022 DONE: done=1 for exactly one cycle regardless of en; next state IDLE with the shift register and received-bit counter cleared.
REQ-023 Bits received during PORT, COUNT, DATA or DONE SHALL NOT contribute to start detection.
REQ-024 A start pattern appearing within DATA payload SHALL be forwarded as data, not detected.
REQ-025 Counters SHALL be sized to hold max(START_LEN, PORT_W, CNT_W, 2**CNT_W-1) without wrap.
REQ-026 busy SHALL be 1 in PORT, COUNT, DATA, DONE and 0 in IDLE.

Reset
REQ-027 rst=0 at a rising edge SHALL force IDLE, clear shift register, bit counter, port, count, sd, sd_valid, done, regardless of en or current state.
REQ-028 Reset asserted mid-frame SHALL abort the frame; no done pulse; a new start pattern SHALL be required after release.
REQ-029 The first enabled edge after rst returns high SHALL be treated as bit 1 of the start-pattern search.

Verification
REQ-030 Defaults, en=1, serIn 1,1,0,1, port 1,0, count 0,0,1,1, data 1,0,1 -> sd_valid=4'b0100 for 3 cycles, sd[2]=1,0,1, done pulse one cycle later, busy low after.
REQ-031 Overlap: serIn 1,1,1,0,1 -> detection on the 5th bit, not earlier; PORT entered next.
REQ-032 Count 0000 after port 11 -> no sd_valid, done one cycle after last count bit.
REQ-033 en toggled 0 every other cycle during a frame (3 data bits) -> identical sd data sequence to REQ-030, sd_valid only after enabled edges.
REQ-034 Payload containing 1101 to port 0 with count 1000 -> all 8 bits on sd[0], no re-detection, exactly one done.
REQ-035 rst=0 during DATA bit 2 of 5 -> all outputs 0 next cycle, busy=0, no done; following frame processed normally.
